// File: rtl/kmap_lut_if.sv
// Evaluation and serial-configuration bus for kmap_lut.
// The master drives requests and table bits; the slave returns results and load status.
interface kmap_lut_if #(
  parameter int unsigned N_IN     = 3,
  parameter int unsigned CHANNELS = 2
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                     in_valid;
  logic [CHANNELS*N_IN-1:0] in_vec;
  logic                     out_valid;
  logic [CHANNELS-1:0]      out;
  logic                     cfg_start;
  logic [CW-1:0]            cfg_chan;
  logic                     cfg_valid;
  logic                     cfg_bit;
  logic                     cfg_abort;
  logic                     cfg_busy;
  logic                     cfg_done;
  logic                     cfg_err;

  modport master (
    output in_valid, in_vec, cfg_start, cfg_chan, cfg_valid, cfg_bit, cfg_abort,
    input  out_valid, out, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    input  in_valid, in_vec, cfg_start, cfg_chan, cfg_valid, cfg_bit, cfg_abort,
    output out_valid, out, cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/kmap_lut.sv
// CHANNELS independent N_IN-input truth-table functions with registered results.
// Tables reload serially into a shadow register and commit in one cycle; evaluation never stalls.
module kmap_lut #(
  parameter int unsigned N_IN     = 3,
  parameter int unsigned CHANNELS = 2,
  parameter logic [CHANNELS*(2**N_IN)-1:0] INIT = {CHANNELS{{((2**N_IN)-1){1'b1}}, 1'b0}}
) (
  input logic       clk,
  input logic       aresetn,
  kmap_lut_if.slave bus
);
  localparam int unsigned TBL = 2**N_IN;
  localparam int unsigned CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned NCH = 2**CW;
  // One bit per encodable channel number: set when that channel exists.
  localparam logic [NCH-1:0] CHAN_OK = NCH'((33'd1 << CHANNELS) - 33'd1);
  localparam logic [N_IN:0]  LAST    = (N_IN+1)'(TBL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [TBL-1:0]      shadow_q;
  logic [N_IN:0]       cnt_q;
  logic [CW-1:0]       chan_q;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] eval_c;
  logic                out_valid_q, busy_q, done_q, err_q;
  logic                start_c, reject_c, load_bit_c, commit_c;

  // Next-state and per-cycle configuration controls.
  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    reject_c   = 1'b0;
    load_bit_c = 1'b0;
    commit_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          if (CHAN_OK[bus.cfg_chan]) begin
            start_c = 1'b1;
            state_d = LOAD;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.cfg_abort) begin
          state_d = IDLE;
        end else if (bus.cfg_valid) begin
          load_bit_c = 1'b1;
          if (cnt_q == LAST) state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Shadow assembly: entry 0 arrives first.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      chan_q   <= '0;
    end else if (start_c) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      chan_q   <= bus.cfg_chan;
    end else if (load_bit_c) begin
      shadow_q[cnt_q[N_IN-1:0]] <= bus.cfg_bit;
      cnt_q                     <= cnt_q + 1'b1;
    end
  end

  // Per-channel active table; only the latched channel takes the shadow on commit.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [TBL-1:0] tbl_q;
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)                          tbl_q <= INIT[g*TBL +: TBL];
      else if (commit_c && chan_q == CW'(g)) tbl_q <= shadow_q;
    end
    assign eval_c[g] = tbl_q[bus.in_vec[g*N_IN +: N_IN]];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (bus.in_valid) out_q <= eval_c;
      out_valid_q <= bus.in_valid;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == COMMIT);
      err_q       <= reject_c;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_busy  = busy_q;
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_kmap_lut.sv
// Self-checking bench for kmap_lut: vector table, directed configuration corner cases,
// and a randomized phase scored against a truth-table model.
module tb_kmap_lut;
  typedef struct {
    logic       in_valid;
    logic [5:0] in_vec;
    logic [1:0] exp_out;
    logic       exp_valid;
  } vec_t;

  localparam logic [7:0] OR_T  = 8'hFE;
  localparam logic [7:0] AND_T = 8'h80;
  localparam logic [7:0] XOR_T = 8'h96;
  localparam logic [7:0] MIX_T = 8'hA5;

  logic clk     = 1'b0;
  logic aresetn = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  kmap_lut_if #(.N_IN(3), .CHANNELS(2)) bus ();
  kmap_lut_if #(.N_IN(3), .CHANNELS(3)) bus3 ();

  kmap_lut #(.N_IN(3), .CHANNELS(2)) dut  (.clk(clk), .aresetn(aresetn), .bus(bus));
  kmap_lut #(.N_IN(3), .CHANNELS(3)) dut3 (.clk(clk), .aresetn(aresetn), .bus(bus3));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_idle();
    bus.cfg_start  = 1'b0; bus.cfg_chan  = '0; bus.cfg_valid  = 1'b0;
    bus.cfg_bit    = 1'b0; bus.cfg_abort = 1'b0;
    bus3.cfg_start = 1'b0; bus3.cfg_chan = '0; bus3.cfg_valid = 1'b0;
    bus3.cfg_bit   = 1'b0; bus3.cfg_abort = 1'b0;
    bus3.in_valid  = 1'b0; bus3.in_vec   = '0;
  endtask

  // Walk both channels over all inputs and compare with the expected tables.
  task automatic sweep(input string name, input logic [7:0] t0, input logic [7:0] t1);
    logic [2:0] a0, a1;
    for (int i = 0; i < 8; i++) begin
      a0 = 3'(i);
      a1 = 3'(7 - i);
      bus.in_valid = 1'b1;
      bus.in_vec   = {a1, a0};
      tick();
      check({name, " out"}, 32'(bus.out), 32'({t1[a1], t0[a0]}));
      check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_vec   = 6'h2a;
    tick();
    check({name, " hold out"}, 32'(bus.out), 32'({t1[3'd0], t0[3'd7]}));
    check({name, " hold out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t       vt [12];
    logic [2:0] a0, a1;
    logic [7:0] mtbl [2];
    logic [7:0] newt;
    logic [1:0] exp_out;
    logic       rch, docommit;
    int         dones, errs, nload, loading, sent, cpend, r;

    for (int i = 0; i < 8; i++) begin
      a0 = 3'(i);
      a1 = 3'(7 - i);
      vt[i] = '{1'b1, {a1, a0}, {|a1, |a0}, 1'b1};
    end
    vt[8]  = '{1'b1, 6'o00, 2'b00, 1'b1};
    vt[9]  = '{1'b0, 6'o77, 2'b00, 1'b0};
    vt[10] = '{1'b1, 6'o40, 2'b10, 1'b1};
    vt[11] = '{1'b0, 6'o00, 2'b10, 1'b0};

    cfg_idle();
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
    #12;
    check("reset out", 32'(bus.out), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset cfg_busy", 32'(bus.cfg_busy), 32'd0);
    check("reset cfg_done", 32'(bus.cfg_done), 32'd0);
    check("reset cfg_err", 32'(bus.cfg_err), 32'd0);
    aresetn = 1'b1;
    tick();

    // Reset tables compute a|b|c on each channel.
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = vt[i].in_valid;
      bus.in_vec   = vt[i].in_vec;
      tick();
      check($sformatf("vec%0d out", i), 32'(bus.out), 32'(vt[i].exp_out));
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].exp_valid));
    end

    // AND into channel 1.
    dones = 0;
    bus.cfg_start = 1'b1; bus.cfg_chan = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("and busy after start", 32'(bus.cfg_busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      bus.cfg_valid = 1'b1; bus.cfg_bit = AND_T[k];
      tick();
      dones += int'(bus.cfg_done);
    end
    bus.cfg_valid = 1'b0;
    tick();
    dones += int'(bus.cfg_done);
    check("and busy after commit", 32'(bus.cfg_busy), 32'd0);
    check("and done pulses", 32'(dones), 32'd1);
    sweep("and", OR_T, AND_T);

    // Gapped XOR into channel 0 with evaluation colliding with COMMIT.
    bus.in_valid  = 1'b1;
    bus.in_vec    = {3'd0, 3'b011};
    bus.cfg_start = 1'b1; bus.cfg_chan = 1'b0;
    tick();
    bus.cfg_start = 1'b0;
    nload = (bus.cfg_busy && !bus.cfg_done) ? 1 : 0;
    for (int t = 0; t < 16; t++) begin
      bus.cfg_valid = (t % 2 == 1);
      bus.cfg_bit   = XOR_T[t / 2];
      tick();
      check("gap old table", 32'(bus.out[0]), 32'd1);
      if (bus.cfg_busy && !bus.cfg_done) nload++;
    end
    check("gap done", 32'(bus.cfg_done), 32'd1);
    bus.cfg_valid = 1'b0;
    tick();
    check("gap commit-cycle eval", 32'(bus.out[0]), 32'd1);
    check("gap busy after commit", 32'(bus.cfg_busy), 32'd0);
    tick();
    check("gap new table", 32'(bus.out[0]), 32'd0);
    check("gap load cycles", 32'(nload), 32'd16);
    bus.in_valid = 1'b0;
    sweep("xor", XOR_T, AND_T);

    // Abort after 5 bits, together with cfg_valid.
    dones = 0;
    bus.cfg_start = 1'b1; bus.cfg_chan = 1'b0;
    tick();
    bus.cfg_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b0;
      tick();
    end
    bus.cfg_abort = 1'b1;
    tick();
    check("abort busy", 32'(bus.cfg_busy), 32'd0);
    bus.cfg_abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      dones += int'(bus.cfg_done);
    end
    bus.cfg_valid = 1'b0;
    check("abort no done", 32'(dones), 32'd0);
    sweep("abort", XOR_T, AND_T);

    // cfg_start during LOAD is ignored; load lands in channel 1.
    dones = 0; errs = 0;
    bus.cfg_start = 1'b1; bus.cfg_chan = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.cfg_start = (k == 3); bus.cfg_chan = 1'b0;
      bus.cfg_valid = 1'b1; bus.cfg_bit = MIX_T[k];
      tick();
      dones += int'(bus.cfg_done);
      errs  += int'(bus.cfg_err);
    end
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
    tick();
    dones += int'(bus.cfg_done);
    errs  += int'(bus.cfg_err);
    check("restart no err", 32'(errs), 32'd0);
    check("restart done", 32'(dones), 32'd1);
    sweep("restart", XOR_T, MIX_T);

    // Nonexistent channel on a 3-channel instance.
    bus3.cfg_start = 1'b1; bus3.cfg_chan = 2'd3;
    tick();
    bus3.cfg_start = 1'b0;
    check("reject err", 32'(bus3.cfg_err), 32'd1);
    check("reject busy", 32'(bus3.cfg_busy), 32'd0);
    tick();
    check("reject err pulse", 32'(bus3.cfg_err), 32'd0);
    check("reject busy stays", 32'(bus3.cfg_busy), 32'd0);

    // Asynchronous reset in the middle of a load.
    bus.in_valid = 1'b1; bus.in_vec = 6'o77;
    bus.cfg_start = 1'b1; bus.cfg_chan = 1'b0;
    tick();
    bus.cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b0;
      tick();
    end
    check("pre-reset out", 32'(bus.out), 32'd3);
    #2 aresetn = 1'b0;
    #1;
    check("async out", 32'(bus.out), 32'd0);
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async busy", 32'(bus.cfg_busy), 32'd0);
    check("async done", 32'(bus.cfg_done), 32'd0);
    #1 aresetn = 1'b1;
    bus.in_valid = 1'b0;
    dones = 0; nload = 0;
    for (int k = 0; k < 8; k++) begin
      bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b0;
      tick();
      dones += int'(bus.cfg_done);
      nload += int'(bus.cfg_busy);
    end
    bus.cfg_valid = 1'b0;
    check("post-reset idle busy", 32'(nload), 32'd0);
    check("post-reset idle done", 32'(dones), 32'd0);
    sweep("reset tables", OR_T, OR_T);

    // Randomized traffic against the truth-table model.
    mtbl[0] = OR_T; mtbl[1] = OR_T;
    exp_out = 2'b00; loading = 0; sent = 0; cpend = 0; rch = 1'b0; newt = '0;
    for (int c = 0; c < 3000; c++) begin
      cfg_idle();
      docommit = (cpend != 0);
      cpend    = 0;
      a0 = 3'($urandom); a1 = 3'($urandom);
      bus.in_valid = (c == 0) || ($urandom_range(3) != 0);
      bus.in_vec   = {a1, a0};
      if (docommit) begin
        bus.cfg_abort = 1'($urandom_range(1));
      end else if (loading == 0) begin
        if ($urandom_range(5) == 0) begin
          rch = 1'($urandom_range(1)); newt = 8'($urandom);
          bus.cfg_start = 1'b1; bus.cfg_chan = rch;
          loading = 1; sent = 0;
        end else if ($urandom_range(7) == 0) begin
          bus.cfg_valid = 1'b1; bus.cfg_bit = 1'($urandom);
        end
      end else begin
        r = int'($urandom_range(19));
        if (r == 0) begin
          bus.cfg_abort = 1'b1; bus.cfg_valid = 1'($urandom_range(1));
          loading = 0;
        end else if (r < 12) begin
          bus.cfg_valid = 1'b1; bus.cfg_bit = newt[3'(sent)];
          sent++;
          if (sent == 8) begin loading = 0; cpend = 1; end
        end else if (r == 19) begin
          bus.cfg_start = 1'b1; bus.cfg_chan = 1'($urandom);
        end
      end
      if (bus.in_valid) exp_out = {mtbl[1][a1], mtbl[0][a0]};
      if (docommit) mtbl[rch] = newt;
      tick();
      check("rand out", 32'(bus.out), 32'(exp_out));
      check("rand out_valid", 32'(bus.out_valid), 32'(bus.in_valid));
      check("rand busy", 32'(bus.cfg_busy), 32'((loading != 0) || (cpend != 0)));
      check("rand done", 32'(bus.cfg_done), 32'(cpend));
      check("rand err", 32'(bus.cfg_err), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
